// File: rtl/ibex_irq_arbiter.sv
// ibex_irq_arbiter: interrupt pending, masking and prioritisation in front of
// the ID-stage controller. Presents one locked maskable request under a
// req/ack handshake plus a separate sticky NMI channel.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   irq_software_i      machine software interrupt (mip bit 3)
//   irq_timer_i         machine timer interrupt    (mip bit 7)
//   irq_external_i      machine external interrupt (mip bit 11)
//   irq_fast_i          fast interrupts, fast i -> mip bit 16+i
//   irq_nm_i            non-maskable interrupt, edge-sensitive
//   mie_i               enable mask in mip layout
//   irq_enable_i        global enable
//   mip_o               pending bits, unused bits read 0
//   irq_req_o           maskable request
//   irq_cause_o         exc_cause_e of the locked request
//   irq_ack_i           controller has taken the request
//   nmi_req_o           NMI pending
//   nmi_ack_i           controller has taken the NMI
//
// Build option: define IBEX_IRQ_SYNC_EN to put a 2-flop synchroniser on every
// interrupt input (adds 2 cycles of input latency).
module ibex_irq_arbiter #(
    parameter int unsigned NumFastIrq = 15,
    parameter logic [31:0] EdgeMask   = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_software_i,
    input  logic                  irq_timer_i,
    input  logic                  irq_external_i,
    input  logic [NumFastIrq-1:0] irq_fast_i,
    input  logic                  irq_nm_i,
    input  logic [31:0]           mie_i,
    input  logic                  irq_enable_i,
    output logic [31:0]           mip_o,
    output logic                  irq_req_o,
    output logic [5:0]            irq_cause_o,
    input  logic                  irq_ack_i,
    output logic                  nmi_req_o,
    input  logic                  nmi_ack_i
);
    localparam int unsigned MipW = 32;
    localparam int unsigned IdW  = 5;
    localparam logic [MipW-1:0] FastMask  = MipW'(((64'd1 << NumFastIrq) - 64'd1) << 16);
    localparam logic [MipW-1:0] ValidMask = FastMask | 32'h0000_0888;
    localparam logic [MipW-1:0] EdgeBits  = EdgeMask & ValidMask;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    logic [MipW-1:0] irq_raw;
    logic [MipW-1:0] irq_in;
    logic            nm_in;

    logic [MipW-1:0] prev_q, mip_q, mip_d;
    logic            nm_prev_q, nmi_q, nmi_d;
    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [5:0]      cause_q, cause_d;
    logic [IdW-1:0]  id_q, id_d;

    logic [MipW-1:0] rise, clr_mask, eligible;
    logic            ack_take;
    logic [IdW-1:0]  win_id;

    // Gather interrupt pins into mip bit layout.
    always_comb begin
        irq_raw                   = '0;
        irq_raw[3]                = irq_software_i;
        irq_raw[7]                = irq_timer_i;
        irq_raw[11]               = irq_external_i;
        irq_raw[16 +: NumFastIrq] = irq_fast_i;
    end

`ifdef IBEX_IRQ_SYNC_EN
    logic [MipW-1:0] sync1_q, sync2_q;
    logic            nm_sync1_q, nm_sync2_q;

    // Two-stage synchroniser for asynchronous interrupt sources.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            nm_sync1_q <= 1'b0;
            nm_sync2_q <= 1'b0;
        end else begin
            sync1_q    <= irq_raw & ValidMask;
            sync2_q    <= sync1_q;
            nm_sync1_q <= irq_nm_i;
            nm_sync2_q <= nm_sync1_q;
        end
    end

    assign irq_in = sync2_q;
    assign nm_in  = nm_sync2_q;
`else
    assign irq_in = irq_raw;
    assign nm_in  = irq_nm_i;
`endif

    // Pending-bit update. A fresh edge overrides a same-cycle ack clear.
    always_comb begin
        ack_take = (state_q == REQ) && irq_ack_i;
        clr_mask = ack_take ? (MipW'(1) << id_q) : '0;
        rise     = irq_in & ~prev_q;
        mip_d    = ((EdgeBits & (rise | (mip_q & ~clr_mask))) |
                    (~EdgeBits & irq_in)) & ValidMask;
        nmi_d    = (nm_in & ~nm_prev_q) | (nmi_q & ~nmi_ack_i);
        eligible = irq_enable_i ? (mip_q & mie_i & ValidMask) : '0;
    end

    // Priority: fast 0 highest, then external, software, timer. Later
    // assignments override earlier, so apply lowest priority first.
    always_comb begin
        win_id = IdW'(7);
        if (eligible[3]) begin
            win_id = IdW'(3);
        end
        if (eligible[11]) begin
            win_id = IdW'(11);
        end
        for (int i = int'(NumFastIrq) - 1; i >= 0; i--) begin
            if (eligible[IdW'(16 + i)]) begin
                win_id = IdW'(16 + i);
            end
        end
    end

    // Request FSM: lock the winner, release on ack or withdrawal.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cause_d = cause_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = win_id;
                    cause_d = {1'b1, win_id};
                end
            end
            REQ: begin
                if (irq_ack_i || !eligible[id_q]) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= '0;
            mip_q     <= '0;
            nm_prev_q <= 1'b0;
            nmi_q     <= 1'b0;
            state_q   <= IDLE;
            req_q     <= 1'b0;
            cause_q   <= '0;
            id_q      <= '0;
        end else begin
            prev_q    <= irq_in;
            mip_q     <= mip_d;
            nm_prev_q <= nm_in;
            nmi_q     <= nmi_d;
            state_q   <= state_d;
            req_q     <= req_d;
            cause_q   <= cause_d;
            id_q      <= id_d;
        end
    end

    assign mip_o       = mip_q;
    assign irq_req_o   = req_q;
    assign irq_cause_o = cause_q;
    assign nmi_req_o   = nmi_q;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Scoreboard bench for ibex_irq_arbiter: stimulus queues expected output
// snapshots (keyed by cycle) and expected causes (one per request rising edge);
// a monitor on the falling edge pops and compares.
module tb_ibex_irq_arbiter;
    localparam int unsigned NFast    = 4;
    localparam logic [31:0] EMask    = 32'h0004_0000;
    localparam logic [31:0] ValidExp = 32'h000F_0888;
`ifdef IBEX_IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif
    localparam logic [3:0] M_MIP   = 4'b0001;
    localparam logic [3:0] M_REQ   = 4'b0010;
    localparam logic [3:0] M_CAUSE = 4'b0100;
    localparam logic [3:0] M_NMI   = 4'b1000;

    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  m;
        logic [31:0] mip;
        logic        req;
        logic [5:0]  cause;
        logic        nmi;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             irq_software_i, irq_timer_i, irq_external_i;
    logic [NFast-1:0] irq_fast_i;
    logic             irq_nm_i;
    logic [31:0]      mie_i;
    logic             irq_enable_i;
    logic [31:0]      mip_o;
    logic             irq_req_o;
    logic [5:0]       irq_cause_o;
    logic             irq_ack_i;
    logic             nmi_req_o;
    logic             nmi_ack_i;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [5:0] cause_q[$];
    exp_t       mon_e;
    logic       req_prev = 1'b0;

    ibex_irq_arbiter #(.NumFastIrq(NFast), .EdgeMask(EMask)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .irq_software_i(irq_software_i), .irq_timer_i(irq_timer_i),
        .irq_external_i(irq_external_i), .irq_fast_i(irq_fast_i),
        .irq_nm_i(irq_nm_i), .mie_i(mie_i), .irq_enable_i(irq_enable_i),
        .mip_o(mip_o), .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
        .irq_ack_i(irq_ack_i), .nmi_req_o(nmi_req_o), .nmi_ack_i(nmi_ack_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input string nm, input logic [3:0] m,
                             input logic [31:0] mip, input logic req,
                             input logic [5:0] cause, input logic nmi);
        exp_t e;
        int   i;
        e.cyc = c; e.name = nm; e.m = m; e.mip = mip;
        e.req = req; e.cause = cause; e.nmi = nmi;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic cleanup();
        irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0;
        irq_fast_i = '0; irq_nm_i = 0; mie_i = '0; irq_enable_i = 0;
        irq_ack_i = 0; nmi_ack_i = 0;
        rst_i = 1;
        step();
        rst_i = 0;
        repeat (3 + L) step();
    endtask

    // Monitor: compare snapshots due this cycle, and each new request's cause.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("mip_unused_zero", mip_o & ~ValidExp, 32'h0);
            if (irq_req_o && !req_prev) begin
                if (cause_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got cause %h expected no request (cycle %0d)",
                             irq_cause_o, cyc);
                end else begin
                    chk("req_cause", 32'(irq_cause_o), 32'(cause_q.pop_front()));
                end
            end
            req_prev <= irq_req_o;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc < cyc) chk({mon_e.name, "_late"}, 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.m[0]) chk({mon_e.name, "_mip"}, mip_o, mon_e.mip);
                if (mon_e.m[1]) chk({mon_e.name, "_req"}, 32'(irq_req_o), 32'(mon_e.req));
                if (mon_e.m[2]) chk({mon_e.name, "_cause"}, 32'(irq_cause_o), 32'(mon_e.cause));
                if (mon_e.m[3]) chk({mon_e.name, "_nmi"}, 32'(nmi_req_o), 32'(mon_e.nmi));
            end
        end
    end

    initial begin
        int k, m, a, p, q, w, e, r;
        rst_i = 1;
        irq_software_i = 0; irq_timer_i = 0; irq_external_i = 0;
        irq_fast_i = '0; irq_nm_i = 0; mie_i = '0; irq_enable_i = 0;
        irq_ack_i = 0; nmi_ack_i = 0;
        step(); step();
        expect_at(cyc, "reset", 4'hF, 32'h0, 1'b0, 6'h0, 1'b0);
        rst_i = 0;
        repeat (3 + L) step();

        // Level timer, ack, idle gap, re-request.
        k = cyc;
        mie_i = 32'h80; irq_enable_i = 1; irq_timer_i = 1;
        expect_at(k + 1 + L, "t1_mip", M_MIP | M_REQ, 32'h80, 1'b0, 6'h0, 1'b0);
        expect_at(k + 2 + L, "t1_req", M_MIP | M_REQ | M_CAUSE, 32'h80, 1'b1, 6'h27, 1'b0);
        cause_q.push_back(6'h27);
        goto(k + 2 + L);
        irq_ack_i = 1;
        expect_at(k + 3 + L, "t1_ack", M_MIP | M_REQ, 32'h80, 1'b0, 6'h0, 1'b0);
        expect_at(k + 4 + L, "t1_rereq", M_REQ | M_CAUSE, 32'h0, 1'b1, 6'h27, 1'b0);
        cause_q.push_back(6'h27);
        step();
        irq_ack_i = 0;
        goto(k + 5 + L);
        cleanup();

        // Priority lock: external held while fast 0 arrives.
        k = cyc;
        mie_i = 32'h0001_0800; irq_enable_i = 1; irq_external_i = 1;
        expect_at(k + 2 + L, "t2_req", M_REQ | M_CAUSE, 32'h0, 1'b1, 6'h2B, 1'b0);
        cause_q.push_back(6'h2B);
        m = k + 2 + L;
        goto(m);
        irq_fast_i = 4'b0001;
        expect_at(m + 1 + L, "t2_lock1", M_MIP | M_REQ | M_CAUSE, 32'h0001_0800, 1'b1, 6'h2B, 1'b0);
        expect_at(m + 2 + L, "t2_lock2", M_MIP | M_REQ | M_CAUSE, 32'h0001_0800, 1'b1, 6'h2B, 1'b0);
        expect_at(m + 3 + L, "t2_ackdrop", M_REQ, 32'h0, 1'b0, 6'h0, 1'b0);
        expect_at(m + 4 + L, "t2_fast0", M_REQ | M_CAUSE, 32'h0, 1'b1, 6'h30, 1'b0);
        cause_q.push_back(6'h30);
        goto(m + 2 + L);
        irq_ack_i = 1;
        step();
        irq_ack_i = 0;
        goto(m + 5 + L);
        cleanup();

        // Edge fast 2: held, cleared by ack; new edge beats same-cycle ack.
        k = cyc;
        mie_i = 32'h0004_0000; irq_enable_i = 1; irq_fast_i = 4'b0100;
        expect_at(k + 1 + L, "t3_edge_set", M_MIP, 32'h0004_0000, 1'b0, 6'h0, 1'b0);
        expect_at(k + 3 + L, "t3_held", M_MIP | M_REQ | M_CAUSE, 32'h0004_0000, 1'b1, 6'h32, 1'b0);
        cause_q.push_back(6'h32);
        step();
        irq_fast_i = '0;
        a = k + 3 + L;
        expect_at(a + 1, "t3_ack_clr", M_MIP | M_REQ, 32'h0, 1'b0, 6'h0, 1'b0);
        goto(a);
        irq_ack_i = 1;
        step();
        irq_ack_i = 0;
        p = a + 2;
        goto(p);
        irq_fast_i = 4'b0100;
        cause_q.push_back(6'h32);
        step();
        irq_fast_i = '0;
        q = p + 5 + L;
        expect_at(q + 1, "t3_edge_wins", M_MIP | M_REQ, 32'h0004_0000, 1'b0, 6'h0, 1'b0);
        expect_at(q + 2, "t3_rereq", M_MIP | M_REQ | M_CAUSE, 32'h0004_0000, 1'b1, 6'h32, 1'b0);
        goto(q - L);
        irq_fast_i = 4'b0100;
        goto(q);
        irq_ack_i = 1;
        cause_q.push_back(6'h32);
        step();
        irq_ack_i = 0;
        irq_fast_i = '0;
        goto(q + 3);
        cleanup();

        // Withdrawal: software request, global enable dropped.
        k = cyc;
        mie_i = 32'h8; irq_enable_i = 1; irq_software_i = 1;
        expect_at(k + 2 + L, "t4_req", M_REQ | M_CAUSE, 32'h0, 1'b1, 6'h23, 1'b0);
        cause_q.push_back(6'h23);
        w = k + 3 + L;
        expect_at(w + 1, "t4_withdraw", M_MIP | M_REQ, 32'h8, 1'b0, 6'h0, 1'b0);
        expect_at(w + 3, "t4_no_rereq", M_MIP | M_REQ, 32'h8, 1'b0, 6'h0, 1'b0);
        goto(w);
        irq_enable_i = 0;
        goto(w + 4);
        cleanup();

        // NMI: merged edges, ack, and edge coincident with ack.
        k = cyc;
        expect_at(k + 1 + L, "t5_nmi_set", M_MIP | M_NMI, 32'h0, 1'b0, 6'h0, 1'b1);
        expect_at(k + 3 + L, "t5_nmi_merge", M_NMI, 32'h0, 1'b0, 6'h0, 1'b1);
        expect_at(k + 6, "t5_pre_ack", M_NMI, 32'h0, 1'b0, 6'h0, 1'b1);
        expect_at(k + 7, "t5_nmi_ack", M_MIP | M_NMI, 32'h0, 1'b0, 6'h0, 1'b0);
        expect_at(k + 8, "t5_nmi_clear", M_NMI, 32'h0, 1'b0, 6'h0, 1'b0);
        irq_nm_i = 1; step(); irq_nm_i = 0; step(); irq_nm_i = 1; step(); irq_nm_i = 0;
        goto(k + 6);
        nmi_ack_i = 1;
        step();
        nmi_ack_i = 0;
        e = k + 8;
        expect_at(e + 1 + L, "t5_nmi_set2", M_NMI, 32'h0, 1'b0, 6'h0, 1'b1);
        expect_at(e + 5 + L, "t5_edge_with_ack", M_NMI, 32'h0, 1'b0, 6'h0, 1'b1);
        expect_at(e + 7 + L, "t5_still", M_NMI, 32'h0, 1'b0, 6'h0, 1'b1);
        goto(e);
        irq_nm_i = 1; step(); irq_nm_i = 0;
        goto(e + 4);
        irq_nm_i = 1;
        goto(e + 4 + L);
        nmi_ack_i = 1;
        step();
        nmi_ack_i = 0;
        irq_nm_i = 0;
        goto(e + 8 + L);
        cleanup();

        // Reset mid-request with everything asserted.
        k = cyc;
        mie_i = 32'hFFFF_FFFF; irq_enable_i = 1; irq_fast_i = 4'hF;
        irq_external_i = 1; irq_software_i = 1; irq_timer_i = 1; irq_nm_i = 1;
        expect_at(k + 1 + L, "t6_mip", M_MIP | M_NMI, 32'h000F_0888, 1'b0, 6'h0, 1'b1);
        expect_at(k + 2 + L, "t6_req", M_REQ | M_CAUSE, 32'h0, 1'b1, 6'h30, 1'b0);
        cause_q.push_back(6'h30);
        r = k + 3 + L;
        expect_at(r + 1, "t6_reset", 4'hF, 32'h0, 1'b0, 6'h0, 1'b0);
        goto(r);
        rst_i = 1;
        step();
        cleanup();

        // Ack while not requesting leaves a pending edge bit alone.
        k = cyc;
        mie_i = 32'h0004_0000; irq_enable_i = 0; irq_fast_i = 4'b0100;
        expect_at(k + 1 + L, "t7_pending", M_MIP | M_REQ, 32'h0004_0000, 1'b0, 6'h0, 1'b0);
        expect_at(k + 4 + L, "t7_ack_ignored", M_MIP | M_REQ, 32'h0004_0000, 1'b0, 6'h0, 1'b0);
        expect_at(k + 5 + L, "t7_late_req", M_REQ | M_CAUSE, 32'h0, 1'b1, 6'h32, 1'b0);
        step();
        irq_fast_i = '0;
        goto(k + 2 + L);
        irq_ack_i = 1;
        step();
        irq_ack_i = 0;
        goto(k + 4 + L);
        irq_enable_i = 1;
        cause_q.push_back(6'h32);
        goto(k + 6 + L);
        cleanup();

        repeat (3) step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("cause_q_drained", 32'(cause_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_irq_arbiter.md
# ibex_irq_arbiter

Parametrised interrupt pending, masking and prioritisation block that sits between the core's interrupt pins and the ID-stage controller. It generalises the fixed software/timer/external/15-fast interrupt set to a configurable fast-interrupt count, with per-channel level or edge sensitivity. It presents one registered request with a stable `exc_cause_e` code under a req/ack handshake. The non-maskable interrupt is handled on a separate sticky channel.

## Interface
- `NumFastIrq`, 15: number of fast interrupts, legal range 1..15; fast i maps to mip bit 16+i and cause {1'b1, 16+i}.
- `EdgeMask`, 32'h0: per mip-bit sensitivity; 1 = rising-edge latched, 0 = level; only bits 3, 7, 11 and 16..16+NumFastIrq-1 are meaningful.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, reset is synchronous and active-high.
- `irq_software_i`, `irq_timer_i`, `irq_external_i` in 1 each: standard machine interrupts.
- `irq_fast_i` in NumFastIrq: fast interrupts.
- `irq_nm_i` in 1: non-maskable interrupt, always edge-sensitive.
- `mie_i` in 32: enable mask in mip bit layout.
- `irq_enable_i` in 1: global enable (mstatus.MIE or priv < M).
- `mip_o` out 32: pending bits; unused bits tied 0.
- `irq_req_o` out 1: maskable interrupt request.
- `irq_cause_o` out 6: `exc_cause_e` of the request.
- `irq_ack_i` in 1: controller has taken the request.
- `nmi_req_o` out 1: NMI pending.
- `nmi_ack_i` in 1: controller has taken the NMI.

## Operation
- Sample stage: each input is registered into `prev`. Level bit: mip = sampled value. Edge bit: set on sampled 0→1, held until acked.
- `prev` resets to 0, so an input already high when reset releases counts as an edge.
- Eligible = mip & mie_i, gated by irq_enable_i.
- Priority, highest first: fast 0 … fast NumFastIrq-1, external (11), software (3), timer (7).
- FSM IDLE/REQ:
  - IDLE: eligible nonzero → REQ. `irq_cause_o` locks to the winner; `irq_req_o` = 1.
  - REQ + `irq_ack_i` → IDLE. Req drops; the locked edge bit clears.
  - REQ + locked source no longer eligible (level dropped, mie cleared, irq_enable_i low) → IDLE. This is a withdrawal; no pending bit changes.
  - A higher-priority arrival in REQ does not change the cause. It is served after ack or withdrawal.
- Same-cycle new edge and ack of that source: the new edge wins and the bit stays set.
- NMI: the edge sets a sticky `nmi_req_o`; `nmi_ack_i` clears it. An edge coinciding with ack leaves it set. Repeated edges while pending merge. NMI is independent of mie/enable and of the FSM.
- Ack while not requesting is ignored.

## Timing
- Reset values: mip_o 0, irq_req_o 0, irq_cause_o 6'h0, nmi_req_o 0, FSM IDLE.
- Input high before edge E0 → mip_o bit set after E0.
- irq_req_o/cause follow one edge after the mip bit sets (E1); total latency 2 cycles.
- NMI: nmi_req_o set after E0.
- Ack at edge E → req low after E. Re-arbitration earliest after E+1, giving one mandatory idle cycle between requests.
- Withdrawal: req low one edge after ineligibility is registered.
- rst_i mid-handshake returns everything to reset values at that edge; pending edge bits are lost.
- irq_cause_o is stable whenever irq_req_o = 1.

## Configuration
- `IBEX_IRQ_SYNC_EN` defined: every interrupt input passes a 2-flop synchroniser before the sample stage. Synchroniser flops reset to 0. All input latencies increase by 2 cycles. Inputs may be asynchronous.
- Undefined: inputs are sampled directly and must be synchronous to clk_i.

## Test plan
- Level timer: mie_i=32'h80, irq_enable_i=1, irq_timer_i=1 → mip_o=32'h80 after 1 cycle; irq_req_o=1, irq_cause_o=6'h27 after 2; ack → req 0, one idle cycle, then req 1 again (level still high).
- Priority/lock: external requesting (cause 6'h2B); assert irq_fast_i[0] → cause stays 6'h2B until ack, then 6'h30 two cycles later.
- Edge fast: EdgeMask bit 18, irq_fast_i[2] pulse 1 cycle → mip_o[18] held; ack → mip_o[18]=0. Pulse coincident with ack → mip_o[18] stays 1.
- Withdrawal: software requesting (6'h23), drop irq_enable_i → irq_req_o 0 next cycle; mip_o[3] still 1.
- NMI: two irq_nm_i edges before ack → single nmi_req_o; nmi_ack_i → 0. Edge with ack → remains 1.
- Reset mid-REQ: rst_i=1 → all outputs 0 next edge; with NumFastIrq=4, mip_o[31:20]=0 always.
